img_stream_tx: RTL and testbench
================================

Name: img_stream_tx

Overview:
- AXI-Stream master that feeds booleanized images into the classifier's 128-bit image input port.
- Reads image rows of WIDTH bits from a row-organized image BRAM (1-cycle read latency).
- Packs pixels LSB-first into 128-bit beats, zero-pads to a fixed BEATS count per image, and asserts tlast on each image's final beat.
- Sits between the host-side image buffer and the classifier top, and honours the classifier's tready backpressure (tready is low during model load and inference).

Parameters:
HEIGHT, 28, image rows
WIDTH, 28, pixels (bits) per row
BEATS, 8, 128-bit beats per image; requires BEATS*128 >= HEIGHT*WIDTH
ADDR_W, 16, row-address width of image BRAM
CNT_W, 16, width of image-count input

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; begin sending img_count images
img_count  in  CNT_W  number of images; sampled on accepted start; 0 -> immediate done
row_addr  out  ADDR_W  BRAM row address = img_idx*HEIGHT + row
row_en  out  1  BRAM read enable; data valid on row_data the following cycle
row_data  in  WIDTH  row bits; bit c = pixel column c
m_tdata  out  128  stream data
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tkeep  out  16  byte enables
m_tlast  out  1  last beat of each image
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final beat of final image is accepted

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; accumulator and counters cleared.
- Reset mid-operation aborts at once:
  - m_tvalid drops the next cycle.
  - No done pulse is issued.
  - The partial image is discarded.
- Pixel ordering: pixel p = row*WIDTH + col goes to beat p/128, bit p%128. Rows may straddle beats.
- Accumulator: register of 128+WIDTH bits plus a fill counter (0..127+WIDTH).
  - Each returned row is ORed in at the current fill offset; fill += WIDTH.
  - When fill >= 128, the low 128 bits move to the output register and the accumulator shifts right by 128; fill -= 128.
- Padding: after the last row, the residual accumulator bits (fill > 0) form one beat with upper bits zero. Further all-zero beats follow until BEATS beats have been emitted for the image.
- m_tkeep = 16'hFFFF on every valid beat; 0 otherwise.
- m_tlast = 1 only on beat index BEATS-1 of each image.
- AXIS rules:
  - Once m_tvalid is high, m_tdata, m_tlast and m_tkeep stay stable until m_tvalid && m_tready.
  - m_tvalid does not wait on m_tready.
  - The output register reloads in the same cycle as a handshake (back-to-back beats at full rate when the accumulator has data).
- Row-read throttling: issue row_en only when the accumulator will not overflow, i.e. fill < 128 after accounting for any in-flight read. Never more than one read outstanding.
- FSM states:
  - IDLE: start accepted -> LOAD. start with img_count == 0 -> done pulse, stay IDLE. start while busy is ignored.
  - LOAD: issue reads for rows 0..HEIGHT-1 and pack them. Last row packed -> PAD.
  - PAD: emit residual and zero beats up to BEATS. Accepted beat BEATS-1 -> NEXT.
  - NEXT: img_idx += 1. If img_idx == img_count -> DONE, else -> LOAD with row = 0.
  - DONE: done pulse for 1 cycle, busy low, -> IDLE.
- Counters:
  - row counter: 0..HEIGHT-1
  - beat counter: 0..BEATS-1, wraps per image
  - img_idx: 0..img_count-1
  - row_addr arithmetic is truncated to ADDR_W.
- busy = (state != IDLE).

Decomposition:
- Shared package:
  - AXIS_DATA_W = 128
  - AXIS_KEEP_W = 16
  - FSM state enum
  - default HEIGHT/WIDTH/BEATS constants, also used by the classifier top
- One natural sub-module: bit_packer (accumulator, fill counter, row insertion, 128-bit extraction). The FSM and AXIS output register stay in img_stream_tx.

Test Plan:
- All-ones image, m_tready=1, img_count=1:
  - 8 beats
  - beats 0-5 = all ones
  - beat 6 = 128'h0000_0000_0000_0000_0000_0000_0000_FFFF
  - beat 7 = 0 with m_tlast=1
  - done pulses 1 cycle after beat 7 handshake
- Each row = 28'h0000001, m_tready=1:
  - beat0 has bits 0, 28, 56, 84 and 112 set, all others 0
  - beat1 has bits 12, 40, 68, 96 and 124 set (pixels 140, 168, ...)
  - continue the check per formula through beat 6
- Random m_tready (50%) on the same image:
  - identical beat sequence
  - m_tdata/m_tlast never change while m_tvalid && !m_tready
  - never more than one row read outstanding
- img_count=2:
  - 16 beats
  - m_tlast on beats 7 and 15
  - row_addr covers 0..27 then 28..55
  - single done pulse
- rst asserted at beat 3 of 8:
  - next cycle m_tvalid=0, busy=0, no done pulse
  - a subsequent start sends the full image from row 0
- start with img_count=0 -> done pulses, no row_en and no m_tvalid. start during busy -> ignored, beat count unchanged.

Source files
------------

// File: rtl/img_stream_tx_pkg.sv
// Shared constants and FSM state type for the image stream transmitter and the classifier top.
package img_stream_tx_pkg;

    localparam int AXIS_DATA_W = 128;
    localparam int AXIS_KEEP_W = 16;

    localparam int DEF_HEIGHT = 28;
    localparam int DEF_WIDTH  = 28;
    localparam int DEF_BEATS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_NEXT,
        ST_DONE
    } tx_state_t;

    // Fill counter must hold 0..AXIS_DATA_W-1+width.
    function automatic int fill_width(input int width);
        return $clog2(AXIS_DATA_W + width);
    endfunction

endpackage

// File: rtl/img_stream_tx_bit_packer.sv
// Row-to-beat packer: ORs WIDTH-bit rows in at the fill offset and hands out the low 128 bits per take.
module img_stream_tx_bit_packer
    import img_stream_tx_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int FILL_W = fill_width(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   row_valid,
    input  logic [WIDTH-1:0]       row_data,
    input  logic                   take,
    output logic [AXIS_DATA_W-1:0] word,
    output logic [FILL_W-1:0]      fill
);

    localparam int ACC_W = AXIS_DATA_W + WIDTH;

    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  shifted;
    logic [ACC_W-1:0]  row_ext;
    logic [FILL_W-1:0] fill_reg;
    logic [FILL_W-1:0] fill_next;
    logic [FILL_W-1:0] base;

    // A take with fill < 128 drains everything: bits above fill are always zero, so the shift clears them.
    always_comb begin
        shifted = acc_reg;
        base    = fill_reg;
        if (take) begin
            shifted = acc_reg >> AXIS_DATA_W;
            base    = (fill_reg >= FILL_W'(AXIS_DATA_W)) ? fill_reg - FILL_W'(AXIS_DATA_W) : '0;
        end
        row_ext   = {{AXIS_DATA_W{1'b0}}, row_data} << base;
        acc_next  = shifted;
        fill_next = base;
        if (row_valid) begin
            acc_next  = shifted | row_ext;
            fill_next = base + FILL_W'(WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_reg  <= '0;
            fill_reg <= '0;
        end else begin
            acc_reg  <= acc_next;
            fill_reg <= fill_next;
        end
    end

    assign word = acc_reg[AXIS_DATA_W-1:0];
    assign fill = fill_reg;

endmodule

// File: rtl/img_stream_tx.sv
// AXI-Stream master that reads booleanized image rows from BRAM and streams them as padded 128-bit beats.
module img_stream_tx
    import img_stream_tx_pkg::*;
#(
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BEATS  = DEF_BEATS,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       img_count,
    output logic [ADDR_W-1:0]      row_addr,
    output logic                   row_en,
    input  logic [WIDTH-1:0]       row_data,
    output logic [AXIS_DATA_W-1:0] m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [AXIS_KEEP_W-1:0] m_tkeep,
    output logic                   m_tlast,
    output logic                   busy,
    output logic                   done
);

    localparam int FILL_W = fill_width(WIDTH);
    localparam int ROW_W  = $clog2(HEIGHT + 1);
    localparam int BEAT_W = $clog2(BEATS + 1);

    tx_state_t              state_reg;
    logic [ROW_W-1:0]       row_cnt_reg;
    logic [BEAT_W-1:0]      beat_cnt_reg;
    logic [CNT_W-1:0]       img_idx_reg;
    logic [CNT_W-1:0]       img_cnt_reg;
    logic [ADDR_W-1:0]      img_base_reg;
    logic [ADDR_W-1:0]      row_addr_reg;
    logic                   row_en_reg;
    logic                   row_vld_reg;
    logic [AXIS_DATA_W-1:0] tdata_reg;
    logic                   tvalid_reg;
    logic                   tlast_reg;
    logic [AXIS_KEEP_W-1:0] tkeep_reg;
    logic                   busy_reg;
    logic                   done_reg;

    logic [AXIS_DATA_W-1:0] pack_word;
    logic [FILL_W-1:0]      pack_fill;
    logic [FILL_W-1:0]      fill_after;
    logic                   hs;
    logic                   out_free;
    logic                   load;
    logic                   issue;

    img_stream_tx_bit_packer #(
        .WIDTH (WIDTH),
        .FILL_W(FILL_W)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_reg == ST_NEXT),
        .row_valid(row_vld_reg),
        .row_data (row_data),
        .take     (load),
        .word     (pack_word),
        .fill     (pack_fill)
    );

    // In PAD every remaining beat is either the residual or zeros, so a load is always possible.
    always_comb begin
        hs       = tvalid_reg && m_tready;
        out_free = !tvalid_reg || m_tready;
        load     = 1'b0;
        if (out_free && (beat_cnt_reg != BEAT_W'(BEATS))) begin
            if (state_reg == ST_PAD)
                load = 1'b1;
            else if (state_reg == ST_LOAD && pack_fill >= FILL_W'(AXIS_DATA_W))
                load = 1'b1;
        end
        fill_after = pack_fill;
        if (load)
            fill_after = (pack_fill >= FILL_W'(AXIS_DATA_W)) ? pack_fill - FILL_W'(AXIS_DATA_W) : '0;
        // Only one read in flight; fill cannot grow before that read lands, so fill_after bounds it.
        issue = (state_reg == ST_LOAD) && (row_cnt_reg != ROW_W'(HEIGHT)) &&
                !row_en_reg && !row_vld_reg && (fill_after < FILL_W'(AXIS_DATA_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            row_cnt_reg  <= '0;
            beat_cnt_reg <= '0;
            img_idx_reg  <= '0;
            img_cnt_reg  <= '0;
            img_base_reg <= '0;
            row_addr_reg <= '0;
            row_en_reg   <= 1'b0;
            row_vld_reg  <= 1'b0;
            tdata_reg    <= '0;
            tvalid_reg   <= 1'b0;
            tlast_reg    <= 1'b0;
            tkeep_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg    <= 1'b0;
            row_en_reg  <= issue;
            row_vld_reg <= row_en_reg;

            if (issue) begin
                row_addr_reg <= img_base_reg + ADDR_W'(row_cnt_reg);
                row_cnt_reg  <= row_cnt_reg + ROW_W'(1);
            end

            if (load) begin
                tdata_reg    <= pack_word;
                tvalid_reg   <= 1'b1;
                tlast_reg    <= (beat_cnt_reg == BEAT_W'(BEATS - 1));
                tkeep_reg    <= '1;
                beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            end else if (hs) begin
                tdata_reg  <= '0;
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
                tkeep_reg  <= '0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (img_count == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg    <= ST_LOAD;
                            busy_reg     <= 1'b1;
                            img_cnt_reg  <= img_count;
                            img_idx_reg  <= '0;
                            img_base_reg <= '0;
                            row_cnt_reg  <= '0;
                            beat_cnt_reg <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    // The last row's data is packed in this same cycle.
                    if (row_vld_reg && row_cnt_reg == ROW_W'(HEIGHT))
                        state_reg <= ST_PAD;
                end
                ST_PAD: begin
                    if (hs && tlast_reg)
                        state_reg <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (img_idx_reg + CNT_W'(1) == img_cnt_reg) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg    <= ST_LOAD;
                        img_idx_reg  <= img_idx_reg + CNT_W'(1);
                        img_base_reg <= img_base_reg + ADDR_W'(HEIGHT);
                        row_cnt_reg  <= '0;
                        beat_cnt_reg <= '0;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign row_addr = row_addr_reg;
    assign row_en   = row_en_reg;
    assign m_tdata  = tdata_reg;
    assign m_tvalid = tvalid_reg;
    assign m_tlast  = tlast_reg;
    assign m_tkeep  = tkeep_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_img_stream_tx.sv
// Scoreboard bench for img_stream_tx: expected beats and row addresses are queued, a monitor pops and compares.
module tb_img_stream_tx;
    import img_stream_tx_pkg::*;

    localparam int H = 28;
    localparam int W = 28;
    localparam int B = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [15:0]    img_count;
    logic [15:0]    row_addr;
    logic           row_en;
    logic [W-1:0]   row_data;
    logic [127:0]   m_tdata;
    logic           m_tvalid;
    logic           m_tready;
    logic [15:0]    m_tkeep;
    logic           m_tlast;
    logic           busy;
    logic           done;

    img_stream_tx #(
        .HEIGHT(H), .WIDTH(W), .BEATS(B), .ADDR_W(16), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .img_count(img_count),
        .row_addr(row_addr), .row_en(row_en), .row_data(row_data),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image BRAM model with one cycle of read latency.
    logic [W-1:0] mem [0:255];
    always @(posedge clk) if (row_en) row_data <= mem[row_addr[7:0]];

    typedef struct {
        logic [127:0] data;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    addr_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int rowen_cnt = 0;
    int valid_cnt = 0;
    int done_cyc = 0;
    int last_hs_cyc = 0;
    bit mon_en = 1'b0;
    bit rdy_rand = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_beat(input int img, input int b);
        logic [127:0] v;
        int p;
        v = '0;
        for (int i = 0; i < 128; i++) begin
            p = b * 128 + i;
            if (p < H * W) v[i] = mem[img * H + p / W][p % W];
        end
        return v;
    endfunction

    // Monitor: pops the scoreboard on every handshake and row read, checks AXIS stability.
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic         prev_last = 1'b0;
    logic         prev_row_en = 1'b0;
    beat_t        mon_e;
    int           mon_a;
    always @(negedge clk) begin
        cyc++;
        if (mon_en && !rst) begin
            if (m_tvalid) chk("tkeep", 128'(m_tkeep), 128'hFFFF);
            if (prev_stall) begin
                chk("stall_valid", 128'(m_tvalid), 128'd1);
                chk("stall_data", m_tdata, prev_data);
                chk("stall_last", 128'(m_tlast), 128'(prev_last));
            end
            if (m_tvalid && m_tready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got %h expected none", m_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", m_tdata, mon_e.data);
                    chk("beat_last", 128'(m_tlast), 128'(mon_e.last));
                end
            end
            if (row_en) begin
                chk("single_outstanding", 128'(prev_row_en), 128'd0);
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got addr %0d expected none", row_addr);
                end else begin
                    mon_a = addr_q.pop_front();
                    chk("row_addr", 128'(row_addr), 128'(mon_a));
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (row_en) rowen_cnt++;
        if (m_tvalid) valid_cnt++;
        prev_stall  = m_tvalid && !m_tready;
        prev_data   = m_tdata;
        prev_last   = m_tlast;
        prev_row_en = row_en;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic push_model(input int img);
        beat_t e;
        for (int b = 0; b < B; b++) begin
            e.data = model_beat(img, b);
            e.last = (b == B - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_addrs(input int img);
        for (int r = 0; r < H; r++) addr_q.push_back(img * H + r);
    endtask

    task automatic start_run(input int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        img_count = 16'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input string name, input int d0, input int h0, input int nbeats);
        int t;
        int gap;
        t = 0;
        while (done_cnt == d0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_timeout: got no done expected done", name);
        end
        repeat (5) @(negedge clk);
        gap = done_cyc - last_hs_cyc;
        chk({name, "_done_count"}, 128'(done_cnt - d0), 128'd1);
        chk({name, "_beat_count"}, 128'(hs_cnt - h0), 128'(nbeats));
        chk({name, "_beats_left"}, 128'(exp_q.size()), 128'd0);
        chk({name, "_reads_left"}, 128'(addr_q.size()), 128'd0);
        chk({name, "_busy_idle"}, 128'(busy), 128'd0);
        chk({name, "_done_after_last"}, 128'(gap >= 1 && gap <= 3), 128'd1);
    endtask

    int   d0, h0, v0, r0, t;
    beat_t he;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        img_count = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_tkeep", 128'(m_tkeep), 128'd0);
        chk("rst_tlast", 128'(m_tlast), 128'd0);
        chk("rst_tdata", m_tdata, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_row_en", 128'(row_en), 128'd0);
        chk("rst_row_addr", 128'(row_addr), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // All-ones image: six full beats, 16-bit residual, one zero beat.
        for (int r = 0; r < H; r++) mem[r] = '1;
        for (int b = 0; b < B; b++) begin
            he.data = (b < 6) ? {128{1'b1}} : (b == 6) ? 128'h0000_0000_0000_0000_0000_0000_0000_FFFF : 128'd0;
            he.last = (b == B - 1);
            exp_q.push_back(he);
        end
        push_addrs(0);
        d0 = done_cnt; h0 = hs_cnt;
        start_run(1);
        finish_run("ones", d0, h0, B);
        $display("test ones: beats=%0d", hs_cnt - h0);

        // Column-0 pixel only: hand-computed first two beats.
        for (int r = 0; r < H; r++) mem[r] = 28'h0000001;
        he.last = 1'b0;
        he.data = 128'h0001_0000_0010_0000_0100_0000_1000_0001;
        exp_q.push_back(he);
        he.data = 128'h1000_0001_0000_0010_0000_0100_0000_1000;
        exp_q.push_back(he);
        for (int b = 2; b < B; b++) begin
            he.data = model_beat(0, b);
            he.last = (b == B - 1);
            exp_q.push_back(he);
        end
        push_addrs(0);
        d0 = done_cnt; h0 = hs_cnt;
        start_run(1);
        finish_run("col0", d0, h0, B);
        $display("test col0: beats=%0d", hs_cnt - h0);

        // Same image under random backpressure.
        rdy_rand = 1'b1;
        push_model(0);
        push_addrs(0);
        d0 = done_cnt; h0 = hs_cnt;
        start_run(1);
        finish_run("backpressure", d0, h0, B);
        rdy_rand = 1'b0;
        $display("test backpressure: beats=%0d", hs_cnt - h0);

        // Two images; second is a diagonal.
        for (int r = 0; r < H; r++) mem[H + r] = {{(W - 1){1'b0}}, 1'b1} << r;
        push_model(0);
        push_model(1);
        push_addrs(0);
        push_addrs(1);
        d0 = done_cnt; h0 = hs_cnt;
        start_run(2);
        finish_run("two_images", d0, h0, 2 * B);
        $display("test two_images: beats=%0d", hs_cnt - h0);

        // Reset after the third beat, then a clean full resend.
        push_model(0);
        push_addrs(0);
        d0 = done_cnt; h0 = hs_cnt;
        start_run(1);
        t = 0;
        while (hs_cnt - h0 < 3 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        chk("abort_reached_beat3", 128'(hs_cnt - h0 >= 3), 128'd1);
        #1;
        rst = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_tvalid", 128'(m_tvalid), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (20) @(negedge clk);
        chk("abort_no_done", 128'(done_cnt - d0), 128'd0);
        mon_en = 1'b1;
        push_model(0);
        push_addrs(0);
        d0 = done_cnt; h0 = hs_cnt;
        start_run(1);
        finish_run("after_abort", d0, h0, B);
        $display("test after_abort: beats=%0d", hs_cnt - h0);

        // Zero images: done only.
        d0 = done_cnt; v0 = valid_cnt; r0 = rowen_cnt;
        start_run(0);
        repeat (10) @(negedge clk);
        chk("zero_done", 128'(done_cnt - d0), 128'd1);
        chk("zero_row_en", 128'(rowen_cnt - r0), 128'd0);
        chk("zero_tvalid", 128'(valid_cnt - v0), 128'd0);
        chk("zero_busy", 128'(busy), 128'd0);
        $display("test zero_count: done=%0d", done_cnt - d0);

        // Start while busy must be ignored.
        push_model(0);
        push_addrs(0);
        d0 = done_cnt; h0 = hs_cnt;
        start_run(1);
        repeat (20) @(negedge clk);
        start_run(5);
        finish_run("start_busy", d0, h0, B);
        repeat (100) @(negedge clk);
        chk("start_busy_no_more_beats", 128'(hs_cnt - h0), 128'(B));
        chk("start_busy_single_done", 128'(done_cnt - d0), 128'd1);
        $display("test start_busy: beats=%0d", hs_cnt - h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
